// File: rtl/doorbell_task_fifo.sv
// Doorbell task FIFO between the DMA engine and the task consumer, with show-ahead read data.
// Optional occupancy/drop statistics are built only when DOORBELL_TASK_FIFO_STATS_EN is defined.
module doorbell_task_fifo #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  pcie_clk,
   input  logic                  rst_n,
   input  logic                  doorbell_task_q_enq_en,
   input  logic [DATA_WIDTH-1:0] doorbell_task_q_data,
   output logic                  doorbell_task_q_full,
   input  logic                  doorbell_task_q_deq_en,
   output logic [DATA_WIDTH-1:0] doorbell_task_q_deq_data,
   output logic                  doorbell_task_q_empty,
   output logic [ADDR_WIDTH:0]   doorbell_task_q_count,
   output logic [ADDR_WIDTH:0]   doorbell_task_q_max_count,
   output logic [15:0]           doorbell_task_q_drop_cnt
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  enq_ok;
   logic                  deq_ok;

   assign doorbell_task_q_full     = (count == DEPTH_CNT);
   assign doorbell_task_q_empty    = (count == '0);
   assign doorbell_task_q_count    = count;
   assign doorbell_task_q_deq_data = mem[rd_ptr];

   // Full/empty come from the registered count, so a pop never frees a slot for a same-cycle write.
   assign enq_ok = doorbell_task_q_enq_en & ~doorbell_task_q_full;
   assign deq_ok = doorbell_task_q_deq_en & ~doorbell_task_q_empty;

   always_comb begin
      count_nxt = count;
      if (enq_ok && !deq_ok) begin
         count_nxt = count + (ADDR_WIDTH+1)'(1);
      end else if (deq_ok && !enq_ok) begin
         count_nxt = count - (ADDR_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge pcie_clk) begin
      if (enq_ok) begin
         mem[wr_ptr] <= doorbell_task_q_data;
      end
   end

   always_ff @(posedge pcie_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (deq_ok) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         count <= count_nxt;
      end
   end

`ifdef DOORBELL_TASK_FIFO_STATS_EN
   logic [ADDR_WIDTH:0] max_count;
   logic [15:0]         drop_cnt;

   always_ff @(posedge pcie_clk or negedge rst_n) begin
      if (!rst_n) begin
         max_count <= '0;
         drop_cnt  <= '0;
      end else begin
         if (count_nxt > max_count) begin
            max_count <= count_nxt;
         end
         if (doorbell_task_q_enq_en && doorbell_task_q_full && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   assign doorbell_task_q_max_count = max_count;
   assign doorbell_task_q_drop_cnt  = drop_cnt;
`else
   assign doorbell_task_q_max_count = '0;
   assign doorbell_task_q_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_doorbell_task_fifo.sv
// Self-checking bench for doorbell_task_fifo: a queue scoreboard checks show-ahead data on every pop.
// Statistics expectations follow DOORBELL_TASK_FIFO_STATS_EN.
module tb_doorbell_task_fifo;

   logic         pcie_clk = 1'b0;
   logic         rst_n    = 1'b0;
   logic         enq_en   = 1'b0;
   logic [127:0] data     = '0;
   logic         full;
   logic         deq_en   = 1'b0;
   logic [127:0] deq_data;
   logic         empty;
   logic [4:0]   count;
   logic [4:0]   max_count;
   logic [15:0]  drop_cnt;

   int errors = 0;
   int checks = 0;
   logic [127:0] sb[$];
   int   m_max  = 0;
   int   m_drop = 0;

   always #5 pcie_clk = ~pcie_clk;

   doorbell_task_fifo #(.DATA_WIDTH(128), .ADDR_WIDTH(4)) dut (
      .pcie_clk                  (pcie_clk),
      .rst_n                     (rst_n),
      .doorbell_task_q_enq_en    (enq_en),
      .doorbell_task_q_data      (data),
      .doorbell_task_q_full      (full),
      .doorbell_task_q_deq_en    (deq_en),
      .doorbell_task_q_deq_data  (deq_data),
      .doorbell_task_q_empty     (empty),
      .doorbell_task_q_count     (count),
      .doorbell_task_q_max_count (max_count),
      .doorbell_task_q_drop_cnt  (drop_cnt)
   );

   // One clock of stimulus, entered and left at the falling edge; pops are scored against the queue head.
   task automatic step(input logic e, input logic [127:0] d, input logic p);
      bit ae, ap;
      enq_en = e;
      data   = d;
      deq_en = p;
      ae = e && (sb.size() < 16);
      ap = p && (sb.size() > 0);
      if (ap) begin
         checks++;
         if (deq_data !== sb[0]) begin
            errors++;
            $display("FAIL pop_data: got %h expected %h", deq_data, sb[0]);
         end
      end
      @(posedge pcie_clk);
      if (ap) void'(sb.pop_front());
      if (ae) sb.push_back(d);
`ifdef DOORBELL_TASK_FIFO_STATS_EN
      if (e && !ae && m_drop != 16'hFFFF) m_drop++;
      if (sb.size() > m_max) m_max = sb.size();
`endif
      @(negedge pcie_clk);
      enq_en = 1'b0;
      deq_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge pcie_clk);
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL reset_flags: got empty=%b full=%b count=%0d expected 1 0 0", empty, full, count);
      end
      rst_n = 1'b1;
      @(negedge pcie_clk);
      checks++;
      if (max_count !== 5'd0 || drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_stats: got max=%0d drop=%0d expected 0 0", max_count, drop_cnt);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 128'(i), 1'b0);
         checks++;
         if (count !== 5'(i) || full !== (i == 16) || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_%0d: got count=%0d full=%b empty=%b expected %0d %b 0",
                     i, count, full, empty, i, (i == 16));
         end
      end
      step(1'b1, 128'hAA, 1'b0);
      checks++;
      if (count !== 5'd16 || full !== 1'b1) begin
         errors++;
         $display("FAIL fill_overflow: got count=%0d full=%b expected 16 1", count, full);
      end
      checks++;
      if (drop_cnt !== 16'(m_drop)) begin
         errors++;
         $display("FAIL fill_drop: got %0d expected %0d", drop_cnt, m_drop);
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 16; i++) begin
         checks++;
         if (deq_data !== 128'(i)) begin
            errors++;
            $display("FAIL drain_order_%0d: got %h expected %h", i, deq_data, 128'(i));
         end
         step(1'b0, '0, 1'b1);
         if (i == 1) begin
            checks++;
            if (full !== 1'b0 || count !== 5'd15) begin
               errors++;
               $display("FAIL drain_full_fall: got full=%b count=%0d expected 0 15", full, count);
            end
         end
      end
      checks++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", empty, count);
      end
      checks++;
      if (max_count !== 5'(m_max)) begin
         errors++;
         $display("FAIL drain_max: got %0d expected %0d", max_count, m_max);
      end
      step(1'b0, '0, 1'b1);
      checks++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         errors++;
         $display("FAIL pop_on_empty: got empty=%b count=%0d expected 1 0", empty, count);
      end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 3; i++) step(1'b1, 128'h100 + 128'(i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 128'h200 + 128'(i), 1'b1);
         checks++;
         if (count !== 5'd3) begin
            errors++;
            $display("FAIL stream_count_%0d: got %0d expected 3", i, count);
         end
      end
      while (sb.size() > 0) step(1'b0, '0, 1'b1);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL stream_empty: got %b expected 1", empty);
      end
   endtask

   task automatic test_empty_both();
      step(1'b1, 128'h5, 1'b1);
      checks++;
      if (count !== 5'd1 || empty !== 1'b0 || deq_data !== 128'h5) begin
         errors++;
         $display("FAIL empty_both: got count=%0d empty=%b data=%h expected 1 0 5", count, empty, deq_data);
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_full_both();
      for (int i = 0; i < 16; i++) step(1'b1, 128'h300 + 128'(i), 1'b0);
      step(1'b1, 128'hBB, 1'b1);
      checks++;
      if (count !== 5'd15 || full !== 1'b0 || deq_data !== 128'h301) begin
         errors++;
         $display("FAIL full_both: got count=%0d full=%b head=%h expected 15 0 301", count, full, deq_data);
      end
      checks++;
      if (drop_cnt !== 16'(m_drop)) begin
         errors++;
         $display("FAIL full_both_drop: got %0d expected %0d", drop_cnt, m_drop);
      end
      while (sb.size() > 0) step(1'b0, '0, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) step(1'b1, 128'h400 + 128'(i), 1'b0);
      @(posedge pcie_clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got empty=%b count=%0d full=%b expected 1 0 0", empty, count, full);
      end
      sb.delete();
      m_max  = 0;
      m_drop = 0;
      @(negedge pcie_clk);
      rst_n = 1'b1;
      @(negedge pcie_clk);
      checks++;
      if (max_count !== 5'd0 || drop_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset_stats: got max=%0d drop=%0d expected 0 0", max_count, drop_cnt);
      end
      step(1'b1, 128'h99, 1'b0);
      step(1'b1, 128'h9A, 1'b0);
      checks++;
      if (deq_data !== 128'h99 || count !== 5'd2) begin
         errors++;
         $display("FAIL post_reset_first: got data=%h count=%0d expected 99 2", deq_data, count);
      end
      while (sb.size() > 0) step(1'b0, '0, 1'b1);
   endtask

   initial begin
      @(negedge pcie_clk);
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_empty_both();
      test_full_both();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/doorbell_task_fifo.md
DOORBELL_TASK_FIFO -- requirements
Module: doorbell_task_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of one doorbell task entry.
REQ-002 Parameter ADDR_WIDTH, default 4: log2 of the depth, so DEPTH = 2^ADDR_WIDTH = 16 entries.
REQ-003 pcie_clk  in  1  sole clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 doorbell_task_q_enq_en  in  1  write strobe from the DMA engine.
REQ-006 doorbell_task_q_data  in  DATA_WIDTH  entry to write.
REQ-007 doorbell_task_q_full  out  1  high when occupancy = DEPTH.
REQ-008 doorbell_task_q_deq_en  in  1  pop strobe from the consumer.
REQ-009 doorbell_task_q_deq_data  out  DATA_WIDTH  head entry, show-ahead.
REQ-010 doorbell_task_q_empty  out  1  high when occupancy = 0.
REQ-011 doorbell_task_q_count  out  ADDR_WIDTH+1  current occupancy, range 0..DEPTH.
REQ-012 doorbell_task_q_max_count  out  ADDR_WIDTH+1  occupancy high-water mark.
REQ-013 doorbell_task_q_drop_cnt  out  16  number of writes rejected because the FIFO was full.

Function
REQ-014 Storage SHALL be DEPTH x DATA_WIDTH, with an ADDR_WIDTH-bit write pointer and read pointer, each wrapping modulo DEPTH.
REQ-015 Occupancy count SHALL be held in a register; full and empty SHALL be decoded combinationally from that register only.
REQ-016 Enqueue accept SHALL be enq_en & !full, with full sampled at the start of the cycle; an accepted write stores data at wr_ptr and increments wr_ptr.
REQ-017 Dequeue accept SHALL be deq_en & !empty; an accepted pop increments rd_ptr.
REQ-018 Write while full: no write, no pointer or count change, no data corruption.
REQ-019 Pop while empty: no pointer or count change.
REQ-020 Simultaneous accepted enqueue and dequeue: count unchanged, both pointers advance.
REQ-021 Enqueue while full together with an accepted pop: the pop proceeds and the enqueue is rejected (full is not bypassed).
REQ-022 Enqueue and pop while empty: the enqueue proceeds and the pop is ignored.
REQ-023 deq_data SHALL equal mem[rd_ptr] combinationally (show-ahead); its value is don't-care while empty.
REQ-024 Latency: a write accepted in cycle N makes empty fall and deq_data valid in cycle N+1.
REQ-025 Latency: a pop accepted in cycle N presents the next entry in cycle N+1.
REQ-026 Latency: full falls the cycle after a pop from the full state.
REQ-027 Entries SHALL be delivered in strict FIFO order across any number of pointer wraps.

Reset
REQ-028 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr, count, max_count and drop_cnt to 0.
REQ-029 While in reset: empty=1, full=0, count=0; memory contents are not cleared.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; the first post-reset write is read back first.
REQ-031 Release of rst_n SHALL be synchronised externally; the block has no internal reset synchroniser.

Configuration
REQ-032 Macro DOORBELL_TASK_FIFO_STATS_EN defined: max_count updates to the count of the next cycle whenever that value exceeds the current max_count.
REQ-033 Macro DOORBELL_TASK_FIFO_STATS_EN defined: drop_cnt increments by 1 for each rejected write (REQ-018, REQ-021) and saturates at 16'hFFFF.
REQ-034 Macro DOORBELL_TASK_FIFO_STATS_EN undefined: max_count and drop_cnt are tied to 0 and their registers are not synthesised; FIFO behaviour is identical.

Verification
REQ-035 Reset, write 0x1..0x10 (16 writes), no pops -> full=1 on cycle after 16th write; count=16; 17th write of 0xAA ignored; drop_cnt=1 (macro on).
REQ-036 From full, pop 16 consecutive cycles -> deq_data 0x1..0x10 in order; empty=1 after last pop; count=0; max_count=16.
REQ-037 Continuous enq+deq for 40 cycles at count=3 -> count stays 3; data order preserved across 2+ pointer wraps.
REQ-038 Empty FIFO, enq_en=1 with 0x5 and deq_en=1 in same cycle -> count=1, deq_data=0x5 next cycle, no pop.
REQ-039 Full FIFO, enq_en and deq_en same cycle -> count=15, head advances, drop_cnt +1, written value never appears.
REQ-040 Fill to 7, drop rst_n mid-cycle -> outputs go empty=1, count=0 asynchronously; next write 0x99 read back first.
